// File: rtl/wb_regfile.sv
// Writeback stage: selects load data or ALU result, commits it to the
// integer register file, serves two bypassed read ports and a commit trace.
module wb_regfile #(
   parameter int XLEN  = 64,
   parameter int NREG  = 32,
   parameter int AW    = 5,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [AW-1:0]    wb_rd,
   input  logic [XLEN-1:0]  wb_read_data,
   input  logic [XLEN-1:0]  wb_alu_res,
   input  logic             wb_regwrite,
   input  logic             wb_memtoreg,
   input  logic [AW-1:0]    rs1_addr,
   input  logic [AW-1:0]    rs2_addr,
   output logic [XLEN-1:0]  rs1_data,
   output logic [XLEN-1:0]  rs2_data,
   output logic [XLEN-1:0]  wb_data,
   output logic             commit_valid,
   output logic [AW-1:0]    commit_rd,
   output logic [XLEN-1:0]  commit_data,
   output logic [CNT_W-1:0] commit_count
);

   logic [XLEN-1:0] regs [NREG];
   logic            we;
   logic            byp;

   assign wb_data = wb_memtoreg ? wb_read_data : wb_alu_res;
   assign we      = wb_regwrite && (wb_rd != '0);
   // No bypass while reset holds: the whole file must read as zero then.
   assign byp     = we && !reset;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (we) begin
         regs[wb_rd] <= wb_data;
      end
   end

   always_comb begin
      rs1_data = '0;
      if (rs1_addr != '0) begin
         rs1_data = (byp && rs1_addr == wb_rd) ? wb_data : regs[rs1_addr];
      end
   end

   always_comb begin
      rs2_data = '0;
      if (rs2_addr != '0) begin
         rs2_data = (byp && rs2_addr == wb_rd) ? wb_data : regs[rs2_addr];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         commit_valid <= 1'b0;
         commit_rd    <= '0;
         commit_data  <= '0;
         commit_count <= '0;
      end else begin
         commit_valid <= we;
         if (we) begin
            commit_rd    <= wb_rd;
            commit_data  <= wb_data;
            commit_count <= commit_count + 1'b1;
         end
      end
   end

endmodule
